// File: rtl/pll_reset_seq_pkg.sv
// =====================================================================
// pll_reset_seq_pkg: state encoding and counter width for pll_reset_seq | rev 1.0
// =====================================================================
`default_nettype none

package pll_reset_seq_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    STABLE     = 2'd1,
    RESET_HOLD = 2'd2,
    RUN        = 2'd3
  } state_t;

  // Clock enables run only while the core clock domain is being driven.
  function automatic logic is_active(input state_t s);
    return (s == RESET_HOLD) || (s == RUN);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pll_reset_seq_sync_2ff.sv
// =====================================================================
// sync_2ff: generic 1-bit two-flop synchronizer, synchronous reset | rev 1.0
// =====================================================================
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pll_reset_seq.sv
// =====================================================================
// pll_reset_seq: PLL lock qualification, core reset hold and cen_20/cen_10 | rev 1.0
// =====================================================================
`default_nettype none

module pll_reset_seq
  import pll_reset_seq_pkg::*;
#(
  parameter int LOCK_HOLD    = 1024,
  parameter int RESET_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  input  logic ext_reset_req,
  output logic sys_reset,
  output logic cen_20,
  output logic cen_10,
  output logic ready
);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(LOCK_HOLD - 1);
  localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);

  logic             locked_s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       phase, phase_nxt;
  logic             active_nxt;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state != WAIT_LOCK && !locked_s) begin
      state_nxt = WAIT_LOCK;
      cnt_nxt   = '0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          cnt_nxt = '0;
          if (locked_s) state_nxt = STABLE;
        end
        STABLE: begin
          if (cnt == HOLD_LAST) begin
            cnt_nxt   = '0;
            state_nxt = RESET_HOLD;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        RESET_HOLD: begin
          if (ext_reset_req) begin
            cnt_nxt = '0;
          end else if (cnt == RESET_LAST) begin
            cnt_nxt   = '0;
            state_nxt = RUN;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        RUN: begin
          cnt_nxt = '0;
          if (ext_reset_req) state_nxt = RESET_HOLD;
        end
        default: begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Phase keeps running across RUN -> RESET_HOLD so the cen cadence never breaks.
  always_comb begin
    active_nxt = is_active(state_nxt);
    phase_nxt  = (is_active(state) && active_nxt) ? phase + 2'd1 : 2'd0;
  end

  // Outputs are registered from next-state values so they align with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      phase     <= 2'd0;
      sys_reset <= 1'b1;
      ready     <= 1'b0;
      cen_20    <= 1'b0;
      cen_10    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      phase     <= phase_nxt;
      sys_reset <= (state_nxt != RUN);
      ready     <= (state_nxt == RUN);
      cen_20    <= active_nxt && !phase_nxt[0];
      cen_10    <= active_nxt && (phase_nxt == 2'd0);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_seq.sv
// =====================================================================
// tb_pll_reset_seq: directed + random stimulus against a behavioural model | rev 1.0
// =====================================================================
`default_nettype none

module tb_pll_reset_seq;

  localparam int LH = 8;
  localparam int RC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b0;
  logic ext_reset_req = 1'b0;
  logic sys_reset, cen_20, cen_10, ready;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode 0=waiting for lock, 1=qualifying, 2=holding reset, 3=running.
  int m_s1 = 0, m_s2 = 0, m_mode = 0, m_elapsed = 0, m_phase = 0;

  pll_reset_seq #(.LOCK_HOLD(LH), .RESET_CYCLES(RC)) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .ext_reset_req (ext_reset_req),
    .sys_reset     (sys_reset),
    .cen_20        (cen_20),
    .cen_10        (cen_10),
    .ready         (ready)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic p, input logic e);
    int  ls;
    bit  was_act;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_mode = 0; m_elapsed = 0; m_phase = 0;
      return;
    end
    ls      = m_s2;
    m_s2    = m_s1;
    m_s1    = int'(p);
    was_act = (m_mode >= 2);
    if (m_mode != 0 && ls == 0) begin
      m_mode = 0; m_elapsed = 0;
    end else begin
      case (m_mode)
        0: if (ls != 0) begin m_mode = 1; m_elapsed = 0; end
        1: begin
          m_elapsed++;
          if (m_elapsed == LH) begin m_mode = 2; m_elapsed = 0; end
        end
        2: begin
          if (e) m_elapsed = 0;
          else begin
            m_elapsed++;
            if (m_elapsed == RC) begin m_mode = 3; m_elapsed = 0; end
          end
        end
        default: if (e) begin m_mode = 2; m_elapsed = 0; end
      endcase
    end
    if (was_act && m_mode >= 2) m_phase = (m_phase + 1) % 4;
    else m_phase = 0;
  endtask

  // One clock: drive, advance model at the edge, compare 1 time unit later.
  task automatic step(input logic r, input logic p, input logic e);
    bit act;
    rst = r; pll_locked = p; ext_reset_req = e;
    @(posedge clk);
    model_edge(r, p, e);
    #1;
    act = (m_mode >= 2);
    check("ready",     ready,     m_mode == 3);
    check("sys_reset", sys_reset, m_mode != 3);
    check("cen_20",    cen_20,    act && (m_phase % 2 == 0));
    check("cen_10",    cen_10,    act && (m_phase == 0));
  endtask

  task automatic run_until_ready(input int max, output int n, output int first_c20,
                                 output int first_c10);
    n = -1; first_c20 = -1; first_c10 = -1;
    for (int i = 1; i <= max; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (first_c20 < 0 && cen_20) first_c20 = i;
      if (first_c10 < 0 && cen_10) first_c10 = i;
      if (ready) begin n = i; return; end
    end
  endtask

  initial begin
    int n, fc20, fc10, low, last10, gaps_bad, c20, c10, bad_coinc;
    bit seen_ready;

    repeat (3) step(1'b1, 1'b0, 1'b0);
    check("reset_sys_reset", sys_reset, 1'b1);
    check("reset_ready",     ready,     1'b0);
    check("reset_cen_20",    cen_20,    1'b0);
    check("reset_cen_10",    cen_10,    1'b0);

    // Power-up sequence
    run_until_ready(40, n, fc20, fc10);
    check_int("powerup_ready_edge", n, 15);
    check_int("powerup_cen20_edge", fc20, 11);
    check_int("powerup_cen10_edge", fc10, 11);

    // Lock glitch at STABLE count 5
    step(1'b1, 1'b0, 1'b0);
    seen_ready = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (ready) seen_ready = 1;
    end
    step(1'b0, 1'b0, 1'b0);
    if (ready) seen_ready = 1;
    run_until_ready(40, n, fc20, fc10);
    check_int("glitch_no_early_ready", int'(seen_ready), 0);
    check_int("glitch_relock_ready_edge", n, 15);

    // ext_reset_req pulse in RUN
    repeat (3) step(1'b0, 1'b1, 1'b0);
    low = 0; last10 = -1; gaps_bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, (i == 5) ? 1'b1 : 1'b0);
      if (!ready) low++;
      if (cen_10) begin
        if (last10 >= 0 && i - last10 != 4) gaps_bad++;
        last10 = i;
      end
    end
    check_int("ext_ready_low_cycles", low, 4);
    check_int("ext_cen10_gaps_bad", gaps_bad, 0);

    // Lock loss coinciding with ext_reset_req
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("loss_still_ready", ready, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("loss_cen_20", cen_20, 1'b0);
    check("loss_cen_10", cen_10, 1'b0);
    check("loss_ready",  ready,  1'b0);
    run_until_ready(40, n, fc20, fc10);
    check_int("loss_relock_ready_edge", n, 15);
    check_int("loss_relock_cen10_edge", fc10, 11);

    // rst asserted in RUN
    repeat (2) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("midrst_sys_reset", sys_reset, 1'b1);
    check("midrst_ready",     ready,     1'b0);
    check("midrst_cen_20",    cen_20,    1'b0);
    check("midrst_cen_10",    cen_10,    1'b0);
    run_until_ready(40, n, fc20, fc10);
    check_int("midrst_ready_edge", n, 15);

    // Ratio over 1000 RUN cycles
    c20 = 0; c10 = 0; bad_coinc = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (cen_20) c20++;
      if (cen_10) c10++;
      if (cen_10 && !cen_20) bad_coinc++;
    end
    check_int("ratio_cen20", c20, 500);
    check_int("ratio_cen10", c10, 250);
    check_int("ratio_coincide", bad_coinc, 0);

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 200) == 0, ($urandom % 40) != 0, ($urandom % 25) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 The module SHALL have parameter LOCK_HOLD, default 1024: the number of cycles the synchronized lock must stay stable before reset sequencing starts (range 1..65535).
REQ-002 The module SHALL have parameter RESET_CYCLES, default 64: the number of cycles sys_reset stays high with clock enables running (range 1..65535).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, the 40 MHz PLL output.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port pll_locked, input, 1 bit: PLL lock, asynchronous to clk.
REQ-006 The module SHALL have port ext_reset_req, input, 1 bit: synchronous request to re-run the reset hold, for example from the OSD or a core reset.
REQ-007 The module SHALL have port sys_reset, output, 1 bit: active-high reset for the core logic.
REQ-008 The module SHALL have port cen_20, output, 1 bit: clock enable, one cycle in every 2.
REQ-009 The module SHALL have port cen_10, output, 1 bit: clock enable, one cycle in every 4.
REQ-010 The module SHALL have port ready, output, 1 bit: high only in state RUN.

Function
REQ-011 pll_locked SHALL pass through a 2-flop synchronizer (locked_s); it has 2 cycles of latency and no other use of the raw input.
REQ-012 The FSM SHALL have 4 states: WAIT_LOCK, STABLE, RESET_HOLD and RUN; there is one shared 16-bit counter.
REQ-013 WAIT_LOCK: the counter is held at 0; when locked_s=1, the FSM goes to STABLE on the next edge.
REQ-014 STABLE: the counter increments every cycle; when the counter reaches LOCK_HOLD-1, the counter clears and the FSM goes to RESET_HOLD. STABLE therefore lasts exactly LOCK_HOLD cycles.
REQ-015 RESET_HOLD: the counter increments every cycle; when the counter reaches RESET_CYCLES-1, the counter clears and the FSM goes to RUN. RESET_HOLD therefore lasts exactly RESET_CYCLES cycles.
REQ-016 RUN: the FSM stays in RUN until a loss of lock or ext_reset_req.
REQ-017 locked_s=0 in any state other than WAIT_LOCK SHALL move the FSM to WAIT_LOCK and clear the counter on the next edge; this has the highest priority after rst.
REQ-018 ext_reset_req=1 in RUN or RESET_HOLD, with locked_s=1, SHALL move the FSM to RESET_HOLD with the counter cleared, which restarts the hold.
REQ-019 ext_reset_req SHALL be ignored in WAIT_LOCK and in STABLE.
REQ-020 sys_reset SHALL be a registered output: 1 in every state except RUN, and it deasserts on the same edge as ready asserts.
REQ-021 ready SHALL be a registered output, equal to (state==RUN).
REQ-022 There SHALL be a 2-bit phase counter, held at 0 in WAIT_LOCK and STABLE, which increments (wrapping 3→0) every cycle in RESET_HOLD and RUN.
REQ-023 cen_20 SHALL be 1 when phase[0]==0, and cen_10 SHALL be 1 when phase==0, both only while in RESET_HOLD or RUN; otherwise both are 0.
REQ-024 Every cen_10 pulse SHALL coincide with a cen_20 pulse.
REQ-025 Neither cen_10 nor cen_20 SHALL have glitches or stretched pulses across state changes.
REQ-026 The phase counter SHALL NOT reset when the FSM re-enters RESET_HOLD from RUN, so the cen cadence stays continuous.

Reset
REQ-027 When rst=1 at a clk edge, the state SHALL become WAIT_LOCK, and the counter, the phase counter and both synchronizer flops SHALL become 0.
REQ-028 During rst the outputs SHALL be sys_reset=1, ready=0, cen_20=0 and cen_10=0.
REQ-029 rst SHALL override every other input in the same cycle.
REQ-030 rst asserted mid-RUN SHALL take effect on the next edge; on release the module SHALL restart the full sequence from WAIT_LOCK.

Structure
REQ-031 A shared package SHALL hold the state enum (WAIT_LOCK/STABLE/RESET_HOLD/RUN) and the counter width constant CNT_W=16.
REQ-032 There SHALL be one sub-module, sync_2ff: a generic 1-bit 2-flop synchronizer with synchronous active-high reset, instantiated for pll_locked.
REQ-033 The FSM, the counters and the cen decode SHALL be inline.

Verification (bench parameters: LOCK_HOLD=8, RESET_CYCLES=4)
REQ-034 Power-up: rst for 3 cycles, then pll_locked raised at edge 0 → STABLE at edge 3, RESET_HOLD at edge 11, with cen_20/cen_10 pulses starting there; sys_reset falls and ready rises at edge 15.
REQ-035 Lock glitch: pll_locked dropped for 1 cycle at STABLE count 5 → return to WAIT_LOCK; after relock the full 8+4 cycles are required again, and ready never pulses.
REQ-036 ext_reset_req pulsed for 1 cycle in RUN → sys_reset=1 and ready=0 for exactly 4 cycles; cen_10 stays strictly periodic (every 4 cycles) across the event.
REQ-037 ext_reset_req and the loss of locked_s in the same cycle → WAIT_LOCK, cens go to 0 on the next edge, and the phase counter is 0.
REQ-038 rst asserted in RUN while pll_locked=1 → all outputs reach their reset values on the next edge; after release, ready rises 15 edges later.
REQ-039 Ratio check over 1000 RUN cycles: cen_20 has exactly 500 pulses and cen_10 exactly 250, and every cen_10 pulse coincides with a cen_20 pulse.
